mem_stage_lsu: RTL and testbench

- Load/store unit of the MEM stage; sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues data-memory requests over a valid/ready bus, formats load data (byte/half/word, sign/zero extend) and presents rd_MemData to MEM/WB.
- Asserts stall_o to freeze upstream pipeline registers and MEM/WB while an access is outstanding.

---
 rtl/mem_stage_lsu.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: valid/ready data-memory requests, load formatting, pipeline stall.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN (adds port misalign_o).
module mem_stage_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [3:0]        mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata,
   output logic [DATA_W-1:0] rd_MemData,
   output logic              stall_o,
   output logic              bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [7:0]        tmo_cnt;
   logic [2:0]        ld_funct3_q;
   logic [1:0]        ld_lane_q;

   logic              mem_op;
   logic              is_load;
   logic              op_legal;
   logic              misaligned;
   logic [3:0]        st_wstrb;
   logic [DATA_W-1:0] st_wdata;

   assign mem_op  = MemRead | MemWrite;
   assign is_load = MemRead;
   assign stall_o = mem_op & (state != S_DONE);

   // Loads accept the sign/zero-extended sizes; stores only SB/SH/SW.
   always_comb begin
      op_legal = 1'b0;
      if (is_load) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
         endcase
      end else begin
         op_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      st_wstrb = 4'b0000;
      st_wdata = '0;
      if (!is_load) begin
         case (funct3[1:0])
            2'b00: begin
               st_wstrb = 4'b0001 << addr[1:0];
               st_wdata = DATA_W'({4{store_data[7:0]}});
            end
            2'b01: begin
               st_wstrb = 4'b0011 << {addr[1], 1'b0};
               st_wdata = DATA_W'({2{store_data[15:0]}});
            end
            default: begin
               st_wstrb = 4'b1111;
               st_wdata = store_data;
            end
         endcase
      end
   end

   function automatic logic [DATA_W-1:0] fmt_load(input logic [2:0]        f3,
                                                  input logic [1:0]        lane,
                                                  input logic [DATA_W-1:0] w);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [DATA_W-1:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = w[{lane[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  r = {{(DATA_W-8){b[7]}}, b};
         3'b100:  r = {{(DATA_W-8){1'b0}}, b};
         3'b001:  r = {{(DATA_W-16){h[15]}}, h};
         3'b101:  r = {{(DATA_W-16){1'b0}}, h};
         3'b010:  r = w;
         default: r = '0;
      endcase
      return r;
   endfunction

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         tmo_cnt       <= 8'd0;
         ld_funct3_q   <= 3'b000;
         ld_lane_q     <= 2'b00;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= 4'b0000;
         rd_MemData    <= '0;
         bus_err_o     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_o    <= 1'b0;
`endif
      end else begin
         bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_o <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (mem_op) begin
                  if (!op_legal) begin
                     state <= S_DONE;
                     if (is_load) rd_MemData <= '0;
                  end else if (misaligned) begin
                     state <= S_DONE;
`ifdef MEM_MISALIGN_TRAP_EN
                     misalign_o <= 1'b1;
`endif
                  end else begin
                     state         <= S_REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_we    <= ~is_load;
                     mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     mem_req_wdata <= st_wdata;
                     mem_req_wstrb <= st_wstrb;
                     ld_funct3_q   <= funct3;
                     ld_lane_q     <= addr[1:0];
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (mem_req_we) begin
                     state <= S_DONE;
                  end else begin
                     state   <= S_RESP;
                     tmo_cnt <= 8'd0;
                  end
               end
            end
            S_RESP: begin
               if (mem_rsp_valid) begin
                  state      <= S_DONE;
                  rd_MemData <= fmt_load(ld_funct3_q, ld_lane_q, mem_rsp_rdata);
               end else if (tmo_cnt == 8'(TIMEOUT)) begin
                  state      <= S_DONE;
                  rd_MemData <= '0;
                  bus_err_o  <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed steps plus random transactions against a
// transaction-level reference model. Define MEM_MISALIGN_TRAP_EN to also exercise misalign_o.
module tb_mem_stage_lsu;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic [31:0] rd_MemData;
   logic        stall_o, bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
      .addr(addr), .store_data(store_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .rd_MemData(rd_MemData), .stall_o(stall_o), .bus_err_o(bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_o(misalign_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Load result from the architectural rules: pick the addressed byte/half, then extend.
   function automatic logic [31:0] model_load(input int f3, input logic [31:0] a, input logic [31:0] w);
      int unsigned lane, b, h;
      lane = a % 4;
      b = (w >> (8 * lane)) % 256;
      h = (w >> (16 * (lane / 2))) % 65536;
      case (f3)
         0: return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
         4: return 32'(b);
         1: return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
         5: return 32'(h);
         2: return w;
         default: return 32'h0;
      endcase
   endfunction

   // rsp_dly: RESP cycles without a response before it arrives; -1 means never (timeout).
   task automatic do_op(input bit mr, input bit mw, input int f3, input logic [31:0] a,
                        input logic [31:0] sd, input int rdly, input int rsp_dly,
                        input logic [31:0] rdata, input string tag);
      bit          load, legal, mis, exp_req, exp_err, accepted, acc_now, req_seen;
      int          exp_stall, stall_cnt, req_wait, rsp_wait;
      logic [31:0] exp_wstrb, exp_wdata;
      load  = mr;
      legal = load ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
      mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = legal && ((((f3 % 4) == 1) && (a % 2 != 0)) || (((f3 % 4) == 2) && (a % 4 != 0)));
`endif
      exp_req = legal && !mis;
      exp_err = exp_req && load && (rsp_dly < 0);
      case (f3 % 4)
         0:       begin exp_wstrb = 32'(1) << (a % 4);       exp_wdata = (sd % 256) * 32'h0101_0101; end
         1:       begin exp_wstrb = 32'(3) << (a % 4 / 2 * 2); exp_wdata = (sd % 65536) * 32'h0001_0001; end
         default: begin exp_wstrb = 32'hF;                    exp_wdata = sd; end
      endcase
      if (!exp_req)      exp_stall = 1;
      else if (!load)    exp_stall = 2 + rdly;
      else               exp_stall = 2 + rdly + ((rsp_dly < 0) ? TMO + 1 : rsp_dly + 1);
      if (load) begin
         if (!legal)            exp_rd = 32'h0;
         else if (mis)          exp_rd = exp_rd;
         else if (rsp_dly < 0)  exp_rd = 32'h0;
         else                   exp_rd = model_load(f3, a, rdata);
      end

      MemRead = mr; MemWrite = mw; funct3 = 3'(f3); addr = a; store_data = sd;
      #1;
      stall_cnt = 0; req_wait = 0; rsp_wait = 0; accepted = 0; req_seen = 0;
      for (int cyc = 0; cyc < 700 && stall_o; cyc++) begin
         stall_cnt++;
         acc_now = 0;
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = $urandom;
         if (mem_req_valid) begin
            req_seen = 1;
            check({tag, " req_addr"}, mem_req_addr, a & 32'hFFFF_FFFC);
            check({tag, " req_we"}, 32'(mem_req_we), 32'(!load));
            if (!load) begin
               check({tag, " req_wstrb"}, 32'(mem_req_wstrb), exp_wstrb);
               check({tag, " req_wdata"}, mem_req_wdata, exp_wdata);
            end
            mem_req_ready = (req_wait == rdly);
            acc_now = mem_req_ready;
            req_wait++;
         end else if (accepted) begin
            if (rsp_dly >= 0 && rsp_wait == rsp_dly) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = rdata;
            end
            rsp_wait++;
         end
         tick;
         if (acc_now) accepted = 1;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;

      check({tag, " stall_release"}, 32'(stall_o), 32'h0);
      check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      check({tag, " req_issued"}, 32'(req_seen), 32'(exp_req));
      check({tag, " valid_done"}, 32'(mem_req_valid), 32'h0);
      check({tag, " bus_err"}, 32'(bus_err_o), 32'(exp_err));
      check({tag, " rd_MemData"}, rd_MemData, exp_rd);
`ifdef MEM_MISALIGN_TRAP_EN
      check({tag, " misalign"}, 32'(misalign_o), 32'(mis));
`endif
      MemRead = 1'b0; MemWrite = 1'b0;
      tick;
      check({tag, " bus_err_pulse"}, 32'(bus_err_o), 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      check({tag, " misalign_pulse"}, 32'(misalign_o), 32'h0);
`endif
      check({tag, " rd_hold"}, rd_MemData, exp_rd);
   endtask

   initial begin
      bit          mr, mw;
      int          f3, rdly, rsp_dly;
      rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0; addr = 32'h0;
      store_data = 32'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
      exp_rd = 32'h0;
      tick; tick;
      check("rst valid", 32'(mem_req_valid), 32'h0);
      check("rst we", 32'(mem_req_we), 32'h0);
      check("rst addr", mem_req_addr, 32'h0);
      check("rst wdata", mem_req_wdata, 32'h0);
      check("rst wstrb", 32'(mem_req_wstrb), 32'h0);
      check("rst rd", rd_MemData, 32'h0);
      check("rst bus_err", 32'(bus_err_o), 32'h0);
      check("rst stall", 32'(stall_o), 32'h0);
      rst = 1'b0;
      tick;

      do_op(1, 0, 2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, "lw");
      do_op(1, 0, 0, 32'h103, 32'h0, 0, 0, 32'h8011_2233, "lb");
      do_op(1, 0, 4, 32'h103, 32'h0, 0, 0, 32'h8011_2233, "lbu");
      do_op(1, 0, 5, 32'h102, 32'h0, 0, 0, 32'h8011_2233, "lhu");
      do_op(1, 0, 1, 32'h102, 32'h0, 1, 2, 32'h8011_2233, "lh");
      do_op(0, 1, 1, 32'h206, 32'h0000_ABCD, 3, 0, 32'h0, "sh");
      do_op(0, 1, 0, 32'h20B, 32'h1234_5677, 0, 0, 32'h0, "sb");
      do_op(0, 1, 2, 32'h210, 32'hCAFE_F00D, 1, 0, 32'h0, "sw");
      do_op(1, 0, 2, 32'h300, 32'h0, 1, -1, 32'h0, "lw_timeout");
      do_op(1, 0, 2, 32'h304, 32'h0, 0, 0, 32'h5555_AAAA, "lw_after_tmo");
      do_op(1, 0, 3, 32'h308, 32'h0, 0, 0, 32'h1111_1111, "ld_illegal");
      do_op(1, 0, 2, 32'h30C, 32'h0, 0, 0, 32'h7777_0001, "lw_reload");
      do_op(0, 1, 4, 32'h310, 32'hFFFF_FFFF, 0, 0, 32'h0, "st_illegal");
      do_op(1, 1, 4, 32'h311, 32'h0, 0, 1, 32'h00C3_0000, "rd_wins");
      do_op(1, 0, 2, 32'h101, 32'h0, 0, 0, 32'h0BAD_F00D, "lw_misalign");

      // Reset while a load waits in RESP; the late response must be ignored.
      MemRead = 1'b1; funct3 = 3'b010; addr = 32'h400;
      tick;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      check("rstmid stall_in_resp", 32'(stall_o), 32'h1);
      rst = 1'b1;
      tick;
      rst = 1'b0; MemRead = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
      tick;
      mem_rsp_valid = 1'b0;
      exp_rd = 32'h0;
      check("rstmid rd", rd_MemData, 32'h0);
      check("rstmid valid", 32'(mem_req_valid), 32'h0);
      check("rstmid addr", mem_req_addr, 32'h0);
      check("rstmid wstrb", 32'(mem_req_wstrb), 32'h0);
      check("rstmid bus_err", 32'(bus_err_o), 32'h0);
      tick;
      check("rstmid rd_hold", rd_MemData, 32'h0);
      do_op(1, 0, 2, 32'h404, 32'h0, 0, 0, 32'h600D_CAFE, "lw_post_rst");

      for (int i = 0; i < 60; i++) begin
         mr      = 1'($urandom_range(0, 1));
         mw      = mr ? ($urandom_range(0, 3) == 0) : 1'b1;
         f3      = $urandom_range(0, 7);
         rdly    = $urandom_range(0, 3);
         rsp_dly = ($urandom_range(0, 14) == 0) ? -1 : $urandom_range(0, 4);
         do_op(mr, mw, f3, $urandom & 32'h0000_FFFF, $urandom, rdly, rsp_dly, $urandom, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
